// File: rtl/sfm_acc_row_sequencer.sv
// Row-level sequencer for the softmax accumulator: splits a command into rows of addend beats,
// then walks each row through accumulate, invert and reciprocal handoff.
module sfm_acc_row_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] row_len_i,
  input  logic [CNT_W-1:0] n_rows_i,
  input  logic             acc_only_i,
  input  logic             addend_valid_i,
  input  logic             addend_ready_i,
  input  logic             acc_done_i,
  input  logic             inv_done_i,
  output logic             addend_en_o,
  output logic             acc_finished_o,
  output logic             acc_only_o,
  output logic             recip_valid_o,
  input  logic             recip_ready_i,
  output logic [CNT_W-1:0] row_idx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [2:0] {
    IDLE, STREAM, WAIT_ACC, WAIT_INV, HANDOFF, DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] row_len_q, row_len_d;
  logic [CNT_W-1:0] n_rows_q, n_rows_d;
  logic [CNT_W-1:0] row_idx_q, row_idx_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             acc_only_q, acc_only_d;
  logic             err_q, err_d;
  logic             beat, row_end;

  assign beat = addend_valid_i & addend_ready_i;

  always_comb begin
    state_d    = state_q;
    row_len_d  = row_len_q;
    n_rows_d   = n_rows_q;
    row_idx_d  = row_idx_q;
    beat_cnt_d = beat_cnt_q;
    acc_only_d = acc_only_q;
    err_d      = err_q;
    row_end    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          row_len_d  = row_len_i;
          n_rows_d   = n_rows_i;
          acc_only_d = acc_only_i;
          row_idx_d  = '0;
          beat_cnt_d = '0;
          err_d      = 1'b0;
          state_d    = (row_len_i != '0 && n_rows_i != '0) ? STREAM : DONE;
        end
      end
      STREAM: begin
        if (beat) begin
          // Compare against len-1 so an all-ones row length never needs a wider counter
          if (beat_cnt_q == row_len_q - CNT_W'(1)) begin
            beat_cnt_d = '0;
            state_d    = WAIT_ACC;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      WAIT_ACC: begin
        if (acc_done_i) begin
          if (acc_only_q) row_end = 1'b1;
          else            state_d = WAIT_INV;
        end
      end
      WAIT_INV: if (inv_done_i)    state_d = HANDOFF;
      HANDOFF:  if (recip_ready_i) row_end = 1'b1;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    if (row_end) begin
      if (row_idx_q == n_rows_q - CNT_W'(1)) begin
        state_d = DONE;
      end else begin
        row_idx_d = row_idx_q + CNT_W'(1);
        state_d   = STREAM;
      end
    end

    // Stray beats set the flag even in the cycle a start clears it
    if (beat && state_q != STREAM) err_d = 1'b1;

    if (clear_i) begin
      state_d    = IDLE;
      row_len_d  = '0;
      n_rows_d   = '0;
      row_idx_d  = '0;
      beat_cnt_d = '0;
      acc_only_d = 1'b0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      row_len_q  <= '0;
      n_rows_q   <= '0;
      row_idx_q  <= '0;
      beat_cnt_q <= '0;
      acc_only_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_len_q  <= row_len_d;
      n_rows_q   <= n_rows_d;
      row_idx_q  <= row_idx_d;
      beat_cnt_q <= beat_cnt_d;
      acc_only_q <= acc_only_d;
      err_q      <= err_d;
    end
  end

  assign addend_en_o    = (state_q == STREAM);
  assign acc_finished_o = (state_q == WAIT_ACC);
  assign recip_valid_o  = (state_q == HANDOFF);
  assign busy_o         = (state_q != IDLE);
  assign done_o         = (state_q == DONE);
  assign acc_only_o     = busy_o & acc_only_q;
  assign row_idx_o      = row_idx_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_sfm_acc_row_sequencer.sv
// Directed bench for sfm_acc_row_sequencer; inputs change and outputs are sampled 1ns after posedge.
module tb_sfm_acc_row_sequencer;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0, start = 1'b0, acc_only = 1'b0;
  logic [CNT_W-1:0] row_len = '0, n_rows = '0;
  logic             a_valid = 1'b0, a_ready = 1'b0, acc_done = 1'b0, inv_done = 1'b0;
  logic             recip_ready = 1'b0;
  logic             addend_en, acc_finished, acc_only_o, recip_valid, busy, done, err;
  logic [CNT_W-1:0] row_idx;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  sfm_acc_row_sequencer #(.CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start),
    .row_len_i(row_len), .n_rows_i(n_rows), .acc_only_i(acc_only),
    .addend_valid_i(a_valid), .addend_ready_i(a_ready),
    .acc_done_i(acc_done), .inv_done_i(inv_done),
    .addend_en_o(addend_en), .acc_finished_o(acc_finished), .acc_only_o(acc_only_o),
    .recip_valid_o(recip_valid), .recip_ready_i(recip_ready),
    .row_idx_o(row_idx), .busy_o(busy), .done_o(done), .err_o(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic beats(input int n);
    a_valid = 1'b1; a_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
    a_valid = 1'b0; a_ready = 1'b0;
  endtask

  task automatic do_start(input logic [CNT_W-1:0] len, input logic [CNT_W-1:0] rows, input logic ao);
    row_len = len; n_rows = rows; acc_only = ao; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_acc();
    acc_done = 1'b1; tick(); acc_done = 1'b0;
  endtask

  task automatic pulse_inv();
    inv_done = 1'b1; tick(); inv_done = 1'b0;
  endtask

  task automatic accept();
    recip_ready = 1'b1; tick(); recip_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_en", addend_en, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    tick();

    // 1: single row with inversion and handoff
    do_start(4, 1, 0);
    chk("t1_en", addend_en, 1);
    chk("t1_busy", busy, 1);
    beats(3);
    chk("t1_still_stream", addend_en, 1);
    chk("t1_no_fin_early", acc_finished, 0);
    beats(1);
    chk("t1_fin", acc_finished, 1);
    chk("t1_en_off", addend_en, 0);
    tick();
    chk("t1_fin_level", acc_finished, 1);
    pulse_acc();
    chk("t1_fin_drop", acc_finished, 0);
    chk("t1_no_rv", recip_valid, 0);
    pulse_inv();
    chk("t1_rv", recip_valid, 1);
    accept();
    chk("t1_done", done, 1);
    chk("t1_rv_off", recip_valid, 0);
    tick();
    chk("t1_done_pulse", done, 0);
    chk("t1_idle", busy, 0);

    // 2: three rows, accumulate only
    do_start(3, 3, 1);
    for (int r = 0; r < 3; r++) begin
      chk("t2_row_idx", row_idx, r);
      chk("t2_acc_only", acc_only_o, 1);
      beats(3);
      chk("t2_fin", acc_finished, 1);
      pulse_acc();
      chk("t2_no_rv", recip_valid, 0);
      if (r < 2) chk("t2_next_stream", addend_en, 1);
    end
    chk("t2_done", done, 1);
    tick();
    chk("t2_done_once", done, 0);
    chk("t2_acc_only_idle", acc_only_o, 0);

    // 3: handoff backpressure, then the next row
    do_start(1, 2, 0);
    beats(1);
    pulse_acc();
    pulse_inv();
    chk("t3_rv0", recip_valid, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_rv_held", recip_valid, 1);
      chk("t3_row_held", row_idx, 0);
    end
    accept();
    chk("t3_next_row", row_idx, 1);
    chk("t3_next_en", addend_en, 1);
    chk("t3_rv_off", recip_valid, 0);
    beats(1);
    pulse_acc();
    pulse_inv();
    accept();
    chk("t3_done", done, 1);
    tick();

    // 4: zero-field start
    do_start(5, 0, 0);
    chk("t4_done", done, 1);
    chk("t4_en", addend_en, 0);
    tick();
    chk("t4_idle", busy, 0);
    chk("t4_done_off", done, 0);

    // 5: stray beat and start while busy
    do_start(2, 2, 1);
    beats(2);
    chk("t5_fin", acc_finished, 1);
    beats(1);
    chk("t5_err", err, 1);
    chk("t5_still_wait", acc_finished, 1);
    do_start(7, 0, 0);
    chk("t5_start_ignored", acc_finished, 1);
    chk("t5_acc_only_kept", acc_only_o, 1);
    pulse_acc();
    chk("t5_row1", row_idx, 1);
    beats(1);
    chk("t5_cnt_unchanged", addend_en, 1);
    beats(1);
    chk("t5_row1_fin", acc_finished, 1);
    chk("t5_err_sticky", err, 1);
    pulse_acc();
    chk("t5_done", done, 1);
    tick();

    // 6: clear in WAIT_INV of row 1, then a fresh command
    do_start(1, 2, 0);
    chk("t6_err_cleared", err, 0);
    beats(1);
    pulse_acc();
    pulse_inv();
    accept();
    beats(1);
    pulse_acc();
    chk("t6_row1", row_idx, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_row_idx", row_idx, 0);
    chk("t6_done", done, 0);
    chk("t6_rv", recip_valid, 0);
    pulse_inv();
    chk("t6_no_done", done, 0);
    chk("t6_no_rv", recip_valid, 0);
    do_start(2, 1, 1);
    beats(2);
    pulse_acc();
    chk("t6_new_done", done, 1);
    tick();
    chk("t6_new_idle", busy, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, observed running expected finished");
    $fatal(1);
  end
endmodule
